// File: rtl/bcd_pkg.sv
// Shared BCD constants and converter state encoding.
package bcd_pkg;
  localparam int BCD_W    = 4;
  localparam int N_DIGITS = 4;
  localparam int BCD_FW   = BCD_W * N_DIGITS;
  localparam int MAX_VAL  = 9999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);
  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Digits and ovf are held registers that change only when a conversion completes.
module bin_to_bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = bcd_pkg::MAX_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundred,
  output logic [3:0]       thousand
);
  import bcd_pkg::*;

  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam int               SR_W    = BCD_FW + BIN_W;
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIN_W - 1);

  function automatic logic [BIN_W-1:0] sat(input logic [BIN_W-1:0] v);
    return (v > MAX_BIN) ? MAX_BIN : v;
  endfunction

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    shreg_q, shreg_d;
  logic [BCD_FW-1:0]  digits_q, digits_d;

  logic [BCD_FW-1:0]  bcd_adj;
  logic [SR_W-1:0]    shifted;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shreg_q[BIN_W + g*BCD_W +: BCD_W]),
      .dout (bcd_adj[g*BCD_W +: BCD_W])
    );
  end

  assign shifted = {bcd_adj[BCD_FW-2:0], shreg_q[BIN_W-1:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    digits_d   = digits_q;
    if (state_q == IDLE) begin
      if (start) begin
        shreg_d    = {{BCD_FW{1'b0}}, sat(bin)};
        ovf_pend_d = (bin > MAX_BIN);
        cnt_d      = '0;
        busy_d     = 1'b1;
        state_d    = SHIFT;
      end
    end else begin
      shreg_d = shifted;
      cnt_d   = cnt_q + CNT_W'(1);
      // Final shift: publish the result straight from the shifter, not from shreg_q.
      if (cnt_q == LAST) begin
        digits_d = shifted[BIN_W +: BCD_FW];
        ovf_d    = ovf_pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      digits_q   <= digits_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign ones     = digits_q[3:0];
  assign tens     = digits_q[7:4];
  assign hundred  = digits_q[11:8];
  assign thousand = digits_q[15:12];
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq; digits are compared as {ovf,thousand,hundred,tens,ones}.
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [3:0]  ones, tens, hundred, thousand;

  int n_chk = 0;
  int n_err = 0;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .ones     (ones),
    .tens     (tens),
    .hundred  (hundred),
    .thousand (thousand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, ovf, thousand, hundred, tens, ones};
  endfunction

  // Present start for exactly one rising edge; returns at the following falling edge.
  task automatic start_conv(input logic [13:0] v);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  task automatic wait_done(input string tag, output int bcyc);
    bit found;
    bit both;
    found = 1'b0;
    both  = 1'b0;
    bcyc  = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (busy && done) both = 1'b1;
      if (done) found = 1'b1;
      else begin
        if (busy) bcyc++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    chk({tag, "_busy_done_excl"}, 32'(both), 32'd0);
  endtask

  initial begin
    int bc;
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs(), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion with latency and pulse width
    start_conv(14'd1234);
    wait_done("c1234", bc);
    chk("c1234_busy_cycles", 32'(bc), 32'd14);
    chk("c1234_digits", outs(), 32'h01234);
    @(negedge clk);
    chk("c1234_done_one_cycle", 32'(done), 32'd0);
    chk("c1234_idle_busy", 32'(busy), 32'd0);

    start_conv(14'd0);
    wait_done("c0", bc);
    chk("c0_digits", outs(), 32'h00000);

    start_conv(14'd9999);
    wait_done("c9999", bc);
    chk("c9999_digits", outs(), 32'h09999);

    start_conv(14'd12000);
    wait_done("c12000", bc);
    chk("c12000_digits_sat", outs(), 32'h19999);

    // start while busy must be ignored
    start_conv(14'd1234);
    chk("ign_digits_held_busy", outs(), 32'h19999);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    repeat (2) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_digits", outs(), 32'h01234);
    chk("ign_idle", 32'(busy), 32'd0);

    // Back-to-back: accept during the done cycle
    start_conv(14'd1234);
    wait_done("b2b_first", bc);
    chk("b2b_first_digits", outs(), 32'h01234);
    start_conv(14'd42);
    chk("b2b_busy_after_done", 32'(busy), 32'd1);
    chk("b2b_hold_while_busy", outs(), 32'h01234);
    repeat (6) @(negedge clk);
    chk("b2b_hold_mid", outs(), 32'h01234);
    wait_done("b2b_second", bc);
    chk("b2b_second_busy_cycles", 32'(bc), 32'd8);
    chk("b2b_second_digits", outs(), 32'h00042);

    // Reset abandons a conversion in progress
    @(negedge clk);
    start_conv(14'd8765);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_digits", outs(), 32'h0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("rst_mid_no_activity", 32'(ndone), 32'd0);
    start_conv(14'd8765);
    wait_done("c8765", bc);
    chk("c8765_busy_cycles", 32'(bc), 32'd14);
    chk("c8765_digits", outs(), 32'h08765);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
